// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared defaults and width clamp for the servo PWM block
package servo_pkg;

    localparam int DEF_PERIOD = 540000;
    localparam int DEF_MIN_PW = 27000;
    localparam int DEF_MAX_PW = 54000;
    localparam int DEF_SLEW   = 1350;
    localparam int DEF_CENTER = (DEF_MIN_PW + DEF_MAX_PW) / 2;

    function automatic int clamp_pw(input int w, input int lo, input int hi);
        if (w < lo) begin
            return lo;
        end
        if (w > hi) begin
            return hi;
        end
        return w;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// rtl/servo_channel.sv - one servo channel: target/current width, slew limit, PWM compare
module servo_channel
    import servo_pkg::*;
#(
    parameter int CNT_W  = 20,
    parameter int CENTER = DEF_CENTER,
    parameter int SLEW   = DEF_SLEW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] counter,
    input  logic             update,
    input  logic             wr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_width,
    output logic             servo,
    output logic             busy
);

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cur;
    logic             en;
    logic [CNT_W-1:0] target_nxt;
    logic [CNT_W-1:0] cur_nxt;
    logic             en_nxt;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   step;

    // Next-state: commands load target/enable; cur only moves at the frame boundary, limited by SLEW.
    // The extra bit on diff/step keeps the distance and the moved value from wrapping.
    always_comb begin
        target_nxt = wr ? wr_width : target;
        en_nxt     = wr ? wr_en : en;
        cur_nxt    = cur;
        step       = (CNT_W+1)'(SLEW);
        if (target >= cur) begin
            diff = {1'b0, target} - {1'b0, cur};
        end else begin
            diff = {1'b0, cur} - {1'b0, target};
        end
        if (update) begin
            if (SLEW == 0 || diff <= step) begin
                cur_nxt = target;
            end else if (target > cur) begin
                cur_nxt = CNT_W'({1'b0, cur} + step);
            end else begin
                cur_nxt = CNT_W'({1'b0, cur} - step);
            end
        end
    end

    // Channel state plus registered PWM output and busy flag (busy tracks the post-edge values).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= CNT_W'(CENTER);
            cur    <= CNT_W'(CENTER);
            en     <= 1'b0;
            servo  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            target <= target_nxt;
            cur    <= cur_nxt;
            en     <= en_nxt;
            servo  <= en & (counter < cur);
            busy   <= (cur_nxt != target_nxt);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with shared frame counter and command decode
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int PERIOD = DEF_PERIOD,
    parameter int MIN_PW = DEF_MIN_PW,
    parameter int MAX_PW = DEF_MAX_PW,
    parameter int SLEW   = DEF_SLEW,
    localparam int CNT_W  = $clog2(PERIOD),
    localparam int CENTER = (MIN_PW + MAX_PW) / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_ch,
    input  logic             cmd_en,
    input  logic [CNT_W-1:0] cmd_width,
    output logic [N_CH-1:0]  servo,
    output logic [N_CH-1:0]  busy,
    output logic             frame_start,
    output logic             cmd_err
);

    logic [CNT_W-1:0] counter;
    logic             running;
    logic             last;
    logic             accept;
    logic             ch_ok;
    logic [CNT_W-1:0] clamped;

    // Ready in every cycle out of reset; a command is taken the cycle it is presented.
    assign cmd_ready = rst_n;
    assign accept    = cmd_valid & cmd_ready;
    assign ch_ok     = ({1'b0, cmd_ch} < 5'(N_CH));
    assign last      = running && (counter == CNT_W'(PERIOD - 1));
    assign clamped   = CNT_W'(clamp_pw(int'(cmd_width), MIN_PW, MAX_PW));

    // Frame counter; 'running' holds the count at 0 for the first post-reset cycle so that
    // cycle is reported as the first frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter     <= '0;
            running     <= 1'b0;
            frame_start <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            running     <= 1'b1;
            counter     <= (last || !running) ? '0 : counter + 1'b1;
            frame_start <= last || !running;
            cmd_err     <= accept && !ch_ok;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_channel #(
            .CNT_W  (CNT_W),
            .CENTER (CENTER),
            .SLEW   (SLEW)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .counter  (counter),
            .update   (last),
            .wr       (accept && ch_ok && (cmd_ch == 4'(i))),
            .wr_en    (cmd_en),
            .wr_width (clamped),
            .servo    (servo[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of servo channels (1..16).
REQ-002 SHALL have parameter PERIOD, default 540000, frame length in clk cycles (20 ms at 27 MHz).
REQ-003 SHALL have parameter MIN_PW, default 27000, minimum pulse width in cycles (1.0 ms).
REQ-004 SHALL have parameter MAX_PW, default 54000, maximum pulse width in cycles (2.0 ms).
REQ-005 SHALL have parameter SLEW, default 1350, maximum pulse-width change per frame in cycles; 0 = no limit.
REQ-006 SHALL derive localparam CNT_W = clog2(PERIOD) and localparam CENTER = (MIN_PW+MAX_PW)/2.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 cmd_valid  input  1  command strobe.
REQ-010 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-011 cmd_ch  input  4  target channel index.
REQ-012 cmd_en  input  1  channel enable carried with the command.
REQ-013 cmd_width  input  CNT_W  requested pulse width in cycles.
REQ-014 servo  output  N_CH  PWM outputs, one bit per channel.
REQ-015 busy  output  N_CH  channel current width differs from target.
REQ-016 frame_start  output  1  one-cycle pulse at start of each frame.
REQ-017 cmd_err  output  1  one-cycle pulse on an accepted command with cmd_ch >= N_CH.

Function
REQ-018 Frame counter SHALL count 0..PERIOD-1 and wrap to 0; frame_start SHALL be high exactly the cycle counter==0.
REQ-019 cmd_ready SHALL be 1 in every cycle except while rst_n is low; every handshake completes in one cycle.
REQ-020 On accept with cmd_ch < N_CH: target[cmd_ch] = clamp(cmd_width, MIN_PW, MAX_PW) and en[cmd_ch] = cmd_en, both visible the next cycle.
REQ-021 On accept with cmd_ch >= N_CH: no state change, cmd_err pulses the next cycle.
REQ-022 Back-to-back commands to the same channel: last accepted wins; no command is dropped.
REQ-023 cur[i] SHALL update only in the cycle counter==PERIOD-1, so a frame never sees a mid-frame width change (glitch-free).
REQ-024 Slew rule at that update: |target-cur| <= SLEW or SLEW==0 -> cur = target; else cur moves SLEW toward target.
REQ-025 A command accepted in the cycle counter==PERIOD-1 SHALL NOT affect that update; it applies from the next frame boundary.
REQ-026 servo[i] SHALL be registered: servo[i] = en[i] & (counter < cur[i]), one cycle latency after counter.
REQ-027 Disabled channel SHALL output 0 continuously; cur/target keep tracking so re-enable resumes at cur.
REQ-028 busy[i] = (cur[i] != target[i]), registered.
REQ-029 Width arithmetic SHALL use CNT_W+1 bits for difference and step to avoid wrap; no signed overflow at MIN_PW/MAX_PW edges.

Reset
REQ-030 rst_n low SHALL immediately force counter=0, servo=0, busy=0, frame_start=0, cmd_err=0, cmd_ready=0.
REQ-031 Reset SHALL set target[i]=cur[i]=CENTER and en[i]=0 for all channels.
REQ-032 Reset asserted mid-frame or mid-slew SHALL abandon the frame; first frame_start follows the first clk edge after release.

Structure
REQ-033 Package servo_pkg SHALL hold default PERIOD, MIN_PW, MAX_PW, SLEW, CENTER and a clamp function.
REQ-034 Per-channel target/cur/en/slew/compare logic SHALL be sub-module servo_channel, instantiated N_CH times by generate; the shared frame counter and command decode stay in servo_pwm_multi.

Verification
REQ-035 Reset release, no commands -> frame_start every 540000 cycles, servo all 0, busy all 0.
REQ-036 cmd ch0 en=1 width=40500, SLEW=0 -> from next frame servo[0] high exactly 40500 cycles per 540000-cycle frame.
REQ-037 cmd ch1 en=1 width=54000 from CENTER=40500, SLEW=1350 -> high time 41850, 43200, ... reaching 54000 after 10 frames; busy[1] falls when cur reaches 54000.
REQ-038 cmd width=1000 and width=100000 -> clamped to 27000 and 54000; cmd_ch=7 with N_CH=4 -> cmd_err pulse, no channel changes.
REQ-039 Command accepted at counter==PERIOD-1 -> no change that frame, applied at following boundary; pulse width never changes mid-frame.
REQ-040 rst_n low mid-pulse at counter 20000 -> servo 0 immediately, after release all channels CENTER and disabled.
